// File: rtl/router_fsm_pkg.sv
// Shared router definitions: port count, header address width and the
// input-path controller state encoding.
package router_fsm_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;
    localparam logic [ADDR_W-1:0] MAX_ADDR     = ADDR_W'(NUM_PORTS - 1);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    // Header address selects a real output FIFO.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return (addr <= MAX_ADDR);
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router input path: header decode,
// load-phase sequencing, FIFO write gating and busy generation.
module router_fsm
    import router_fsm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pkt_valid,
    input  logic [ADDR_W-1:0]     data_in,
    input  logic                  fifo_full,
    input  logic [NUM_PORTS-1:0]  fifo_empty,
    input  logic [NUM_PORTS-1:0]  soft_reset,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    output logic [ADDR_W-1:0]     dest_addr,
    output logic                  detect_addr,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  full_state,
    output logic                  laf_state,
    output logic                  rst_int_reg,
    output logic                  write_enb_reg,
    output logic                  busy
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_dest_addr;
    logic                w_hdr_ok;
    logic                w_hdr_empty;
    logic                w_sel_empty;
    logic                w_sel_soft;

    // Header qualification and per-port status selection; out-of-range
    // addresses never index the per-port vectors.
    always_comb begin
        w_hdr_ok    = pkt_valid && addr_valid(data_in);
        w_hdr_empty = 1'b0;
        w_sel_empty = 1'b0;
        w_sel_soft  = 1'b0;
        if (addr_valid(data_in)) begin
            w_hdr_empty = fifo_empty[data_in];
        end else begin
            w_hdr_empty = 1'b0;
        end
        if (addr_valid(r_dest_addr)) begin
            w_sel_empty = fifo_empty[r_dest_addr];
            w_sel_soft  = soft_reset[r_dest_addr];
        end else begin
            w_sel_empty = 1'b0;
            w_sel_soft  = 1'b0;
        end
    end

    // State and destination registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= DECODE_ADDRESS;
            r_dest_addr <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            if ((r_state == DECODE_ADDRESS) && w_hdr_ok) begin
                r_dest_addr <= data_in;
            end
        end
    end

    // Next-state logic: soft reset of the selected port overrides the table.
    always_comb begin
        w_next_state = DECODE_ADDRESS;
        if ((r_state != DECODE_ADDRESS) && w_sel_soft) begin
            w_next_state = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (w_hdr_ok) begin
                        w_next_state = w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end else begin
                        w_next_state = DECODE_ADDRESS;
                    end
                end
                LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        w_next_state = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        w_next_state = LOAD_PARITY;
                    end else begin
                        w_next_state = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    w_next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        w_next_state = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        w_next_state = LOAD_PARITY;
                    end else begin
                        w_next_state = LOAD_DATA;
                    end
                end
                LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    w_next_state = w_sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                default: w_next_state = DECODE_ADDRESS;
            endcase
        end
    end

    // Moore output decode of the state register.
    always_comb begin
        detect_addr   = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b0;
        case (r_state)
            DECODE_ADDRESS:     detect_addr = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_TILL_EMPTY:    busy = 1'b1;
            default:            detect_addr = 1'b0;
        endcase
    end

    assign dest_addr = r_dest_addr;

endmodule

// File: tb/tb_router_fsm.sv
// Directed, table-driven bench for router_fsm with a few hand-written
// multi-cycle sequences around the wait-till-empty path.
module tb_router_fsm;
    import router_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rstn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_empty, soft_reset;
    logic [1:0] dest_addr;
    logic       detect_addr, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, write_enb_reg, busy;
    logic [7:0] outs;

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .dest_addr(dest_addr), .detect_addr(detect_addr), .lfd_state(lfd_state),
        .ld_state(ld_state), .full_state(full_state), .laf_state(laf_state),
        .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy)
    );

    // {detect, lfd, ld, full, laf, rst_int, write_enb, busy}
    assign outs = {detect_addr, lfd_state, ld_state, full_state, laf_state,
                   rst_int_reg, write_enb_reg, busy};

    localparam logic [7:0] E_DA  = 8'b1000_0000;
    localparam logic [7:0] E_LFD = 8'b0100_0011;
    localparam logic [7:0] E_LD  = 8'b0010_0010;
    localparam logic [7:0] E_FFS = 8'b0001_0001;
    localparam logic [7:0] E_LAF = 8'b0000_1011;
    localparam logic [7:0] E_LP  = 8'b0000_0011;
    localparam logic [7:0] E_CPE = 8'b0000_0101;
    localparam logic [7:0] E_WTE = 8'b0000_0001;

    typedef struct {
        logic       rstn;
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp_o;
        logic [1:0] exp_dest;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic pv, input logic [1:0] din,
                       input logic ff, input logic [2:0] fe, input logic [2:0] sr,
                       input logic pd, input logic lpv,
                       input logic [7:0] eo, input logic [1:0] ed);
        vec_t v;
        v.rstn = r; v.pv = pv; v.din = din; v.ff = ff; v.fe = fe; v.sr = sr;
        v.pd = pd; v.lpv = lpv; v.exp_o = eo; v.exp_dest = ed;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic pv, input logic [1:0] din,
                         input logic ff, input logic [2:0] fe, input logic [2:0] sr,
                         input logic pd, input logic lpv);
        rstn = r; pkt_valid = pv; data_in = din; fifo_full = ff;
        fifo_empty = fe; soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] eo, input logic [1:0] ed);
        n_cmp++;
        if (outs !== eo) begin
            n_bad++;
            $display("FAIL %s[%0d] strobes: got %b expected %b", nm, idx, outs, eo);
        end
        n_cmp++;
        if (dest_addr !== ed) begin
            n_bad++;
            $display("FAIL %s[%0d] dest_addr: got %0d expected %0d", nm, idx, dest_addr, ed);
        end
    endtask

    initial begin
        bit got_lfd;
        rstn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        @(negedge clk);

        // rstn pv din ff fe sr pd lpv | expected strobes, dest_addr
        add(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DA,  2'd0); // reset
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd1); // header port 1
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd1);
        add(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd1);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LP,  2'd1); // parity byte
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_CPE, 2'd1);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DA,  2'd1);
        for (int i = 0; i < 4; i++)                                           // invalid address
            add(1'b1, 1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DA, 2'd1);
        add(1'b1, 1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, E_WTE, 2'd2); // port 2 busy
        add(1'b1, 1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, E_WTE, 2'd2);
        add(1'b1, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd2);
        add(1'b1, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd2);
        for (int i = 0; i < 3; i++)                                           // full for 3 cycles
            add(1'b1, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FFS, 2'd2);
        add(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, E_LAF, 2'd2);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, E_LP,  2'd2);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_CPE, 2'd2);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DA,  2'd2);
        add(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd0); // CPE -> FFS path
        add(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd0);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LP,  2'd0);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_CPE, 2'd0);
        add(1'b1, 1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FFS, 2'd0);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LAF, 2'd0);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, E_DA,  2'd0); // parity_done
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd1); // LAF -> LD path
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd1);
        add(1'b1, 1'b1, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FFS, 2'd1);
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LAF, 2'd1);
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd1);
        add(1'b1, 1'b0, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FFS, 2'd1); // full beats !pv
        add(1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, E_LAF, 2'd1);
        add(1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, E_LP,  2'd1);
        add(1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_CPE, 2'd1);
        add(1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DA,  2'd1);
        add(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd0); // soft reset
        add(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd0);
        add(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0, E_LD,  2'd0);
        add(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0, E_DA,  2'd0);
        add(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b0, E_DA,  2'd0);
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b111, 1'b0, 1'b0, E_LFD, 2'd1); // ignored in DA
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0, E_DA,  2'd1);
        add(1'b1, 1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, E_WTE, 2'd2);
        add(1'b1, 1'b1, 2'd2, 1'b0, 3'b111, 3'b100, 1'b0, 1'b0, E_DA,  2'd2); // srst beats empty
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd1);
        add(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd1);
        add(1'b1, 1'b1, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FFS, 2'd1);
        add(1'b0, 1'b1, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_DA,  2'd0); // rstn mid-FFS
        add(1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DA,  2'd0);

        foreach (vq[i]) begin
            drive(vq[i].rstn, vq[i].pv, vq[i].din, vq[i].ff, vq[i].fe, vq[i].sr,
                  vq[i].pd, vq[i].lpv);
            chk("vec", i, vq[i].exp_o, vq[i].exp_dest);
        end

        // Port 0 not empty: hold in WTE; a non-selected soft reset is ignored.
        drive(1'b1, 1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0);
        chk("wte_enter", 0, E_WTE, 2'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 2'd3, 1'b0, 3'b110, (i == 2) ? 3'b110 : 3'b000, 1'b0, 1'b0);
            chk("wte_hold", i, E_WTE, 2'd0);
        end

        // Release port 0 and wait (bounded) for the first-data phase.
        got_lfd = 1'b0;
        for (int i = 0; i < 4 && !got_lfd; i++) begin
            drive(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
            got_lfd = lfd_state;
        end
        n_cmp++;
        if (!got_lfd) begin
            n_bad++;
            $display("FAIL wte_release: got lfd_state=%b expected 1 within 4 cycles", lfd_state);
        end
        chk("wte_lfd", 0, E_LFD, 2'd0);
        drive(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        chk("wte_ld", 0, E_LD, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
